// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register access controller: host response status
// encoding and the controller state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_STATE_IDLE     = 2'd0,
        RGGEN_STATE_ACCESS   = 2'd1,
        RGGEN_STATE_RESPONSE = 2'd2
    } rggen_controller_state;

endpackage

// File: rtl/rggen_register_response_mux.sv
// Combinational gather of per-slot select/ready/status/read data into a single
// decode-valid flag, a ready hit and the muxed status and read data.
module rggen_register_response_mux
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1
)(
    input  logic [TOTAL_REGISTERS-1:0]            i_select,
    input  logic [TOTAL_REGISTERS-1:0]            i_ready,
    input  logic [2*TOTAL_REGISTERS-1:0]          i_status,
    input  logic [DATA_WIDTH*TOTAL_REGISTERS-1:0] i_read_data,
    output logic                                  select_valid,
    output logic                                  ready_hit,
    output rggen_status                           status,
    output logic [DATA_WIDTH-1:0]                 read_data
);

    logic [1:0] status_or;

    // Exactly one slot selecting: non-zero and a power of two.
    assign select_valid = (|i_select) &&
        ((i_select & (i_select - TOTAL_REGISTERS'(1))) == '0);

    // Unselected slots cannot contribute a ready.
    assign ready_hit = |(i_select & i_ready);

    always_comb begin
        status_or = '0;
        read_data = '0;
        for (int n = 0; n < TOTAL_REGISTERS; n++) begin
            if (i_select[n]) begin
                status_or = status_or | i_status[2*n+:2];
                read_data = read_data | i_read_data[DATA_WIDTH*n+:DATA_WIDTH];
            end
        end
    end

    assign status = rggen_status'(status_or);

endmodule

// File: rtl/rggen_register_access_controller.sv
// Host-side access controller: latches one command, broadcasts it to all
// register slots, waits for the selected slot and returns one response.
module rggen_register_access_controller
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int TIMEOUT_CYCLES  = 0
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]              i_cmd_address,
    input  logic                                  i_cmd_write,
    input  logic [DATA_WIDTH-1:0]                 i_cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]               i_cmd_strobe,
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic [1:0]                            o_rsp_status,
    output logic [DATA_WIDTH-1:0]                 o_rsp_read_data,
    output logic                                  o_request,
    output logic [ADDRESS_WIDTH-1:0]              o_address,
    output logic                                  o_write,
    output logic [DATA_WIDTH-1:0]                 o_write_data,
    output logic [DATA_WIDTH/8-1:0]               o_strobe,
    input  logic [TOTAL_REGISTERS-1:0]            i_select,
    input  logic [TOTAL_REGISTERS-1:0]            i_ready,
    input  logic [2*TOTAL_REGISTERS-1:0]          i_status,
    input  logic [DATA_WIDTH*TOTAL_REGISTERS-1:0] i_read_data
);

    localparam logic [1:0] IDLE     = RGGEN_STATE_IDLE;
    localparam logic [1:0] ACCESS   = RGGEN_STATE_ACCESS;
    localparam logic [1:0] RESPONSE = RGGEN_STATE_RESPONSE;

    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TIMEOUT_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [1:0]               state;
    logic [COUNTER_WIDTH-1:0] counter;
    rggen_status              rsp_status;
    logic                     select_valid;
    logic                     ready_hit;
    rggen_status              mux_status;
    logic [DATA_WIDTH-1:0]    mux_read_data;
    logic                     timeout_hit;

    rggen_register_response_mux #(
        .DATA_WIDTH      (DATA_WIDTH),
        .TOTAL_REGISTERS (TOTAL_REGISTERS)
    ) u_response_mux (
        .i_select     (i_select),
        .i_ready      (i_ready),
        .i_status     (i_status),
        .i_read_data  (i_read_data),
        .select_valid (select_valid),
        .ready_hit    (ready_hit),
        .status       (mux_status),
        .read_data    (mux_read_data)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (counter == COUNTER_WIDTH'(TIMEOUT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            counter         <= '0;
            o_address       <= '0;
            o_write         <= 1'b0;
            o_write_data    <= '0;
            o_strobe        <= '0;
            rsp_status      <= RGGEN_OKAY;
            o_rsp_read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_address    <= i_cmd_address;
                        o_write      <= i_cmd_write;
                        o_write_data <= i_cmd_write_data;
                        o_strobe     <= i_cmd_strobe;
                        counter      <= '0;
                        state        <= ACCESS;
                    end
                end
                // Decode error outranks ready, and ready outranks timeout.
                ACCESS: begin
                    if (!select_valid) begin
                        rsp_status      <= RGGEN_DECODE_ERROR;
                        o_rsp_read_data <= '0;
                        state           <= RESPONSE;
                    end else if (ready_hit) begin
                        rsp_status      <= mux_status;
                        o_rsp_read_data <= o_write ? '0 : mux_read_data;
                        state           <= RESPONSE;
                    end else if (timeout_hit) begin
                        rsp_status      <= RGGEN_SLAVE_ERROR;
                        o_rsp_read_data <= '0;
                        state           <= RESPONSE;
                    end else begin
                        counter <= counter + COUNTER_WIDTH'(1);
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        o_rsp_read_data <= '0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready  = (state == IDLE);
    assign o_request    = (state == ACCESS);
    assign o_rsp_valid  = (state == RESPONSE);
    assign o_rsp_status = rsp_status;

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Scenario bench for rggen_register_access_controller with four slots and an
// eight-cycle timeout; expected responses go through a scoreboard queue.
module tb_rggen_register_access_controller;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TR = 4;
    localparam int TO = 8;

    typedef struct {
        logic [1:0]    status;
        logic [DW-1:0] data;
        int            lat;
        int            req;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [AW-1:0]     i_cmd_address;
    logic              i_cmd_write;
    logic [DW-1:0]     i_cmd_write_data;
    logic [DW/8-1:0]   i_cmd_strobe;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [1:0]        o_rsp_status;
    logic [DW-1:0]     o_rsp_read_data;
    logic              o_request;
    logic [AW-1:0]     o_address;
    logic              o_write;
    logic [DW-1:0]     o_write_data;
    logic [DW/8-1:0]   o_strobe;
    logic [TR-1:0]     i_select;
    logic [TR-1:0]     i_ready;
    logic [2*TR-1:0]   i_status;
    logic [DW*TR-1:0]  i_read_data;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // values reported by run_access
    int            r_lat;
    int            r_req;
    bit            r_bcast_ok;
    bit            r_timeout;

    always #5 clk = ~clk;

    rggen_register_access_controller #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .TOTAL_REGISTERS (TR),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_address    (i_cmd_address),
        .i_cmd_write      (i_cmd_write),
        .i_cmd_write_data (i_cmd_write_data),
        .i_cmd_strobe     (i_cmd_strobe),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_status     (o_rsp_status),
        .o_rsp_read_data  (o_rsp_read_data),
        .o_request        (o_request),
        .o_address        (o_address),
        .o_write          (o_write),
        .o_write_data     (o_write_data),
        .o_strobe         (o_strobe),
        .i_select         (i_select),
        .i_ready          (i_ready),
        .i_status         (i_status),
        .i_read_data      (i_read_data)
    );

    // Drives one command from IDLE and plays the slave side until o_rsp_valid.
    // ready_at is the 1-based ACCESS cycle when the selected slot becomes
    // ready (0 = never); noise is extra ready on other slots.
    task automatic run_access(input logic [AW-1:0] addr, input logic wr,
                              input logic [DW-1:0] wdata, input logic [3:0] strb,
                              input logic [TR-1:0] sel, input int ready_at,
                              input logic [TR-1:0] noise);
        int k;
        i_cmd_valid      = 1'b1;
        i_cmd_address    = addr;
        i_cmd_write      = wr;
        i_cmd_write_data = wdata;
        i_cmd_strobe     = strb;
        i_select         = sel;
        i_ready          = noise;
        @(posedge clk); #1;
        i_cmd_valid      = 1'b0;
        i_cmd_address    = ~addr;
        i_cmd_write_data = ~wdata;
        i_cmd_strobe     = ~strb;
        r_req = 0;
        r_bcast_ok = 1'b1;
        k = 1;
        while (o_rsp_valid !== 1'b1 && k < 64) begin
            i_ready = ((ready_at != 0 && k >= ready_at) ? sel : '0) | noise;
            @(negedge clk);
            if (o_request === 1'b1) r_req++;
            if (o_address !== addr || o_write !== wr || o_write_data !== wdata || o_strobe !== strb)
                r_bcast_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        r_lat = k;
        r_timeout = (k >= 64);
        i_ready = '0;
    endtask

    task automatic handshake();
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        i_select    = '0;
    endtask

    task automatic set_slot(input int n, input logic [1:0] st, input logic [DW-1:0] rd);
        i_status[2*n+:2]     = st;
        i_read_data[DW*n+:DW] = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", o_cmd_ready); end
        total++; if (o_request !== 1'b0) begin bad++; $display("FAIL reset_request got=%b exp=0", o_request); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", o_rsp_valid); end
        total++; if (o_rsp_status !== 2'b00 || o_rsp_read_data !== '0) begin bad++;
            $display("FAIL reset_rsp got=%h/%h exp=0/0", o_rsp_status, o_rsp_read_data); end
        total++; if (o_address !== '0 || o_write !== 1'b0 || o_write_data !== '0 || o_strobe !== '0) begin bad++;
            $display("FAIL reset_bcast got=%h/%b/%h/%h exp=0", o_address, o_write, o_write_data, o_strobe); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_response(input string name);
        exp_t e;
        e = exp_q.pop_front();
        total++; if (r_timeout) begin bad++; $display("FAIL %s_no_response got=none exp=valid", name); end
        total++; if (o_rsp_status !== e.status) begin bad++;
            $display("FAIL %s_status got=%h exp=%h", name, o_rsp_status, e.status); end
        total++; if (o_rsp_read_data !== e.data) begin bad++;
            $display("FAIL %s_data got=%h exp=%h", name, o_rsp_read_data, e.data); end
        total++; if (r_lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, r_lat, e.lat); end
        total++; if (r_req !== e.req) begin bad++; $display("FAIL %s_request_cycles got=%0d exp=%0d", name, r_req, e.req); end
        total++; if (!r_bcast_ok) begin bad++; $display("FAIL %s_broadcast_stable got=changed exp=stable", name); end
    endtask

    task automatic test_read();
        set_slot(2, 2'b00, 32'hDEADBEEF);
        exp_q.push_back('{2'b00, 32'hDEADBEEF, 2, 1});
        run_access(16'h0008, 1'b0, 32'h0, 4'h0, 4'b0100, 1, 4'b0000);
        check_response("read_slot2");
        handshake();
        set_slot(3, 2'b01, 32'hA5A5_0F0F);
        exp_q.push_back('{2'b01, 32'hA5A5_0F0F, 3, 2});
        run_access(16'h000C, 1'b0, 32'h0, 4'hF, 4'b1000, 2, 4'b0000);
        check_response("read_slot3_exokay");
        handshake();
    endtask

    task automatic test_write();
        set_slot(1, 2'b00, 32'hFFFF_FFFF);
        exp_q.push_back('{2'b00, 32'h0, 5, 4});
        run_access(16'h0004, 1'b1, 32'h12345678, 4'b0011, 4'b0010, 4, 4'b0000);
        check_response("write_slot1");
        handshake();
    endtask

    task automatic test_decode_error();
        exp_q.push_back('{2'b11, 32'h0, 2, 1});
        run_access(16'h0040, 1'b0, 32'h0, 4'h0, 4'b0000, 1, 4'b1111);
        check_response("decode_none");
        handshake();
        set_slot(0, 2'b00, 32'h1111_1111);
        exp_q.push_back('{2'b11, 32'h0, 2, 1});
        run_access(16'h0000, 1'b0, 32'h0, 4'h0, 4'b0101, 1, 4'b0000);
        check_response("decode_multi");
        handshake();
    endtask

    task automatic test_timeout();
        set_slot(0, 2'b00, 32'h0BAD_F00D);
        exp_q.push_back('{2'b10, 32'h0, 9, 8});
        run_access(16'h0000, 1'b0, 32'h0, 4'h0, 4'b0001, 0, 4'b1110);
        check_response("timeout");
        handshake();
        exp_q.push_back('{2'b00, 32'h0BAD_F00D, 9, 8});
        run_access(16'h0000, 1'b0, 32'h0, 4'h0, 4'b0001, 8, 4'b0000);
        check_response("ready_at_timeout");
        handshake();
    endtask

    task automatic test_hold();
        bit stable;
        set_slot(2, 2'b00, 32'hCAFE_0001);
        exp_q.push_back('{2'b00, 32'hCAFE_0001, 3, 2});
        run_access(16'h0008, 1'b0, 32'h0, 4'h0, 4'b0100, 2, 4'b0000);
        check_response("hold_read");
        set_slot(2, 2'b10, 32'h0000_BEEF);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_cmd_ready !== 1'b0 || o_rsp_status !== 2'b00 ||
                o_rsp_read_data !== 32'hCAFE_0001 || o_request !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL hold_stable got=changed exp=stable"); end
        @(posedge clk); #1;
        handshake();
        total++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin bad++;
            $display("FAIL hold_release got=valid%b/ready%b exp=0/1", o_rsp_valid, o_cmd_ready); end
        total++; if (o_rsp_read_data !== '0) begin bad++;
            $display("FAIL hold_data_clear got=%h exp=0", o_rsp_read_data); end
        set_slot(2, 2'b00, 32'h7777_8888);
        exp_q.push_back('{2'b00, 32'h7777_8888, 2, 1});
        run_access(16'h0008, 1'b0, 32'h0, 4'h0, 4'b0100, 1, 4'b0000);
        check_response("after_hold");
        handshake();
    endtask

    task automatic check_reset_values(input string name);
        total++; if (o_request !== 1'b0 || o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin bad++;
            $display("FAIL %s_ctrl got=req%b/vld%b/rdy%b exp=0/0/1", name, o_request, o_rsp_valid, o_cmd_ready); end
        total++; if (o_address !== '0 || o_write !== 1'b0 || o_write_data !== '0 || o_strobe !== '0 ||
                     o_rsp_status !== 2'b00 || o_rsp_read_data !== '0) begin bad++;
            $display("FAIL %s_values got=%h/%b/%h/%h/%h/%h exp=0", name, o_address, o_write,
                     o_write_data, o_strobe, o_rsp_status, o_rsp_read_data); end
    endtask

    task automatic test_reset_inflight();
        // reset while waiting in ACCESS
        i_cmd_valid      = 1'b1;
        i_cmd_address    = 16'h0004;
        i_cmd_write      = 1'b1;
        i_cmd_write_data = 32'h5555_AAAA;
        i_cmd_strobe     = 4'hF;
        i_select         = 4'b0010;
        i_ready          = '0;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (o_request !== 1'b1) begin bad++; $display("FAIL rst_access_setup got=%b exp=1", o_request); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("rst_in_access");
        // reset while holding a response
        set_slot(3, 2'b01, 32'h1234_ABCD);
        run_access(16'h000C, 1'b0, 32'h0, 4'h3, 4'b1000, 1, 4'b0000);
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_read_data !== 32'h1234_ABCD) begin bad++;
            $display("FAIL rst_response_setup got=%b/%h exp=1/1234abcd", o_rsp_valid, o_rsp_read_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("rst_in_response");
        i_select = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst              = 1'b1;
        i_cmd_valid      = 1'b0;
        i_cmd_address    = '0;
        i_cmd_write      = 1'b0;
        i_cmd_write_data = '0;
        i_cmd_strobe     = '0;
        i_rsp_ready      = 1'b0;
        i_select         = '0;
        i_ready          = '0;
        i_status         = '0;
        i_read_data      = '0;
        @(posedge clk); #1;
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_timeout();
        test_hold();
        test_reset_inflight();
        total++; if (exp_q.size() != 0) begin bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
